fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the instruction memory (IM).

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: default widths, program length and
// the FSM state encoding also seen by the debug port.
package fetch_stage_pkg;

  localparam int DEF_PC_W     = 8;
  localparam int DEF_INSTR_W  = 8;
  localparam int DEF_PROG_LEN = 6;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    FETCH  = 2'd1,
    HALT   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the IM address combinationally,
// registers the returned code byte and hands it to the decoder.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter int              PROG_LEN = DEF_PROG_LEN,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    im_pc,
  input  logic [INSTR_W-1:0] im_code,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  output logic               halted,
  output fetch_state_e       state
);

  // Handshake instr_valid/dec_ready: a transfer happens on every rising edge
  // where both are high; while instr_valid && !dec_ready the instr, instr_pc
  // and pc registers hold; instr_valid never depends on dec_ready.

  localparam logic [PC_W:0]   PROG_END = (PC_W + 1)'(PROG_LEN);
  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W - 1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc;
  logic            pc_in_prog;
  logic            tgt_in_prog;
  logic            slot_free;
  logic            load;

  assign im_pc       = pc;
  assign pc_in_prog  = ({1'b0, pc} < PROG_END);
  assign tgt_in_prog = ({1'b0, br_target} < PROG_END);
  assign slot_free   = !instr_valid || dec_ready;
  assign load        = (state == FETCH) && slot_free && pc_in_prog;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      state       <= WARMUP;
    end else if (br_taken) begin
      // Redirect flushes the register; a same-cycle transfer was still consumed.
      pc          <= br_target;
      instr_valid <= 1'b0;
      if (state == WARMUP) begin
        state <= FETCH;
      end else if (tgt_in_prog) begin
        state  <= FETCH;
        halted <= 1'b0;
      end else begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end else begin
      unique case (state)
        WARMUP: begin
          state <= FETCH;
        end
        FETCH: begin
          if (load) begin
            instr       <= im_code;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_ONE;
          end else if (!pc_in_prog && slot_free) begin
            // Past the end with the last instruction gone: stop fetching.
            instr_valid <= 1'b0;
            state       <= HALT;
            halted      <= 1'b1;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a driver issues scenarios and queues the
// expected decoder transfers; a negedge monitor pops and compares them.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   im_pc;
  logic [7:0]   im_code;
  logic         br_taken;
  logic [7:0]   br_target;
  logic [7:0]   instr;
  logic [7:0]   instr_pc;
  logic         instr_valid;
  logic         dec_ready;
  logic         halted;
  fetch_state_e state;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .im_pc(im_pc), .im_code(im_code),
    .br_taken(br_taken), .br_target(br_target), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .halted(halted), .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Instruction memory beside the fetch stage: {11,22,33,44,55,66}
  function automatic logic [7:0] im_val(input logic [7:0] a);
    case (a)
      8'd0: return 8'h11;
      8'd1: return 8'h22;
      8'd2: return 8'h33;
      8'd3: return 8'h44;
      8'd4: return 8'h55;
      8'd5: return 8'h66;
      default: return 8'h00;
    endcase
  endfunction

  always_comb im_code = im_val(im_pc);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int first, input int last);
    for (int p = first; p <= last; p++) exp_q.push_back({8'(p), im_val(8'(p))});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_im_pc", 32'(im_pc), 32'h0);
    check("rst_state", 32'(state), 32'(WARMUP));
  endtask

  // scoreboard monitor: one pop per transfer edge
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset === 1'b1 && instr_valid && dec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer: unexpected transfer pc=%0d instr=%h, expected none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          errors++;
          $display("FAIL xfer: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                   instr_pc, instr, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; br_taken = 1'b0; br_target = 8'd0; dec_ready = 1'b1;
    tick();
    check_reset_vals();

    // Full-rate run through the whole program
    reset = 1'b1;
    push_run(0, 5);
    tick();
    check("warm_state", 32'(state), 32'(FETCH));
    check("warm_valid", 32'(instr_valid), 32'h0);
    tick();
    check("first_valid", 32'(instr_valid), 32'h1);
    check("first_instr", 32'(instr), 32'h11);
    check("first_pc", 32'(instr_pc), 32'h0);
    repeat (5) tick();
    check("last_instr", 32'(instr), 32'h66);
    check("last_pc", 32'(instr_pc), 32'd5);
    check("last_not_halted", 32'(halted), 32'h0);
    tick();
    check("end_halted", 32'(halted), 32'h1);
    check("end_valid", 32'(instr_valid), 32'h0);
    check("end_state", 32'(state), 32'(HALT));
    check("end_im_pc", 32'(im_pc), 32'd6);
    check("run1_q_empty", 32'(exp_q.size()), 32'h0);

    // Restart from HALT, back-pressure, then a redirect back to 1
    br_taken = 1'b1; br_target = 8'd0;
    push_run(0, 4);
    push_run(1, 5);
    tick();
    check("unhalt_halted", 32'(halted), 32'h0);
    check("unhalt_valid", 32'(instr_valid), 32'h0);
    check("unhalt_state", 32'(state), 32'(FETCH));
    br_taken = 1'b0;
    tick();
    check("restart_instr", 32'(instr), 32'h11);
    tick();
    check("pre_stall_instr", 32'(instr), 32'h22);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", 32'(instr), 32'h22);
      check("stall_instr_pc", 32'(instr_pc), 32'd1);
      check("stall_pc", 32'(im_pc), 32'd2);
    end
    dec_ready = 1'b1;
    tick();
    check("post_stall_instr", 32'(instr), 32'h33);
    check("post_stall_pc", 32'(instr_pc), 32'd2);
    repeat (2) tick();
    check("pre_br_pc", 32'(instr_pc), 32'd4);
    br_taken = 1'b1; br_target = 8'd1;
    tick();
    check("flush_valid", 32'(instr_valid), 32'h0);
    check("flush_im_pc", 32'(im_pc), 32'd1);
    br_taken = 1'b0;
    tick();
    check("redir_instr", 32'(instr), 32'h22);
    check("redir_pc", 32'(instr_pc), 32'd1);
    check("redir_valid", 32'(instr_valid), 32'h1);
    repeat (4) tick();
    check("run2_last", 32'(instr), 32'h66);
    tick();
    check("run2_halted", 32'(halted), 32'h1);
    check("run2_q_empty", 32'(exp_q.size()), 32'h0);

    // Redirect beyond the program halts immediately
    br_taken = 1'b1; br_target = 8'd2;
    push_run(2, 2);
    tick();
    br_taken = 1'b0;
    tick();
    check("oob_pre_instr", 32'(instr), 32'h33);
    br_taken = 1'b1; br_target = 8'd9;
    tick();
    check("oob_halted", 32'(halted), 32'h1);
    check("oob_state", 32'(state), 32'(HALT));
    check("oob_valid", 32'(instr_valid), 32'h0);
    check("oob_im_pc", 32'(im_pc), 32'd9);
    br_taken = 1'b0;
    tick();
    check("oob_hold_halted", 32'(halted), 32'h1);
    check("oob_hold_im_pc", 32'(im_pc), 32'd9);
    check("oob_q_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-stream with a live, stalled instruction
    br_taken = 1'b1; br_target = 8'd0;
    tick();
    br_taken = 1'b0; dec_ready = 1'b0;
    tick();
    check("mid_live", 32'(instr_valid), 32'h1);
    reset = 1'b0;
    tick();
    check_reset_vals();
    reset = 1'b1; dec_ready = 1'b1;
    push_run(0, 5);
    tick();
    check("rel1_valid", 32'(instr_valid), 32'h0);
    tick();
    check("rel2_instr", 32'(instr), 32'h11);
    check("rel2_valid", 32'(instr_valid), 32'h1);
    repeat (5) tick();
    tick();
    check("run4_halted", 32'(halted), 32'h1);
    check("run4_q_empty", 32'(exp_q.size()), 32'h0);

    // Redirect during WARMUP: pc moves, WARMUP still completes
    reset = 1'b0;
    tick();
    reset = 1'b1; br_taken = 1'b1; br_target = 8'd3;
    tick();
    check("wu_br_state", 32'(state), 32'(FETCH));
    check("wu_br_im_pc", 32'(im_pc), 32'd3);
    check("wu_br_valid", 32'(instr_valid), 32'h0);
    br_taken = 1'b0;
    push_run(3, 5);
    tick();
    check("wu_br_instr", 32'(instr), 32'h44);
    check("wu_br_pc", 32'(instr_pc), 32'd3);
    repeat (2) tick();
    tick();
    check("run5_halted", 32'(halted), 32'h1);
    check("run5_q_empty", 32'(exp_q.size()), 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
